// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package mdu_pkg;

  localparam logic [3:0] MDU_NOP   = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;
  localparam logic [3:0] MDU_MADD  = 4'd9;
  localparam logic [3:0] MDU_MADDU = 4'd10;
  localparam logic [3:0] MDU_MSUB  = 4'd11;
  localparam logic [3:0] MDU_MSUBU = 4'd12;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;
  localparam int MDU_CNT_W_DEF       = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for several cycles and commit HI/LO at the end.
  function automatic logic is_multicycle(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO next-value datapath for mult/div (and accumulate ops
// when MDU_MADD_EN is defined). Divide-by-zero returns the current HI/LO.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] next_hi_o,
  output logic [31:0] next_lo_o
);

  logic signed [63:0] sa, sb, prod_s;
  logic        [63:0] prod_u;
  logic               a_neg, b_neg;
  logic        [31:0] mag_a, mag_b, q_mag, r_mag, q_s, r_s, q_u, r_u;

  assign sa     = {{32{a_i[31]}}, a_i};
  assign sb     = {{32{b_i[31]}}, b_i};
  assign prod_s = sa * sb;
  assign prod_u = {32'b0, a_i} * {32'b0, b_i};

  // Signed divide on magnitudes; 0x80000000 / -1 naturally yields 0x80000000 r 0.
  assign a_neg = a_i[31];
  assign b_neg = b_i[31];
  assign mag_a = a_neg ? (~a_i + 32'd1) : a_i;
  assign mag_b = b_neg ? (~b_i + 32'd1) : b_i;
  assign q_mag = mag_a / mag_b;
  assign r_mag = mag_a % mag_b;
  assign q_s   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = a_neg ? (~r_mag + 32'd1) : r_mag;
  assign q_u   = a_i / b_i;
  assign r_u   = a_i % b_i;

  always_comb begin
    {next_hi_o, next_lo_o} = {hi_i, lo_i};
    case (op_i)
      MDU_MULT:  {next_hi_o, next_lo_o} = $unsigned(prod_s);
      MDU_MULTU: {next_hi_o, next_lo_o} = prod_u;
      MDU_DIV:   if (b_i != 32'd0) {next_hi_o, next_lo_o} = {r_s, q_s};
      MDU_DIVU:  if (b_i != 32'd0) {next_hi_o, next_lo_o} = {r_u, q_u};
`ifdef MDU_MADD_EN
      MDU_MADD:  {next_hi_o, next_lo_o} = {hi_i, lo_i} + $unsigned(prod_s);
      MDU_MADDU: {next_hi_o, next_lo_o} = {hi_i, lo_i} + prod_u;
      MDU_MSUB:  {next_hi_o, next_lo_o} = {hi_i, lo_i} - $unsigned(prod_s);
      MDU_MSUBU: {next_hi_o, next_lo_o} = {hi_i, lo_i} - prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy drives the ID stall.
// Define MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF,
  parameter int CNT_W       = MDU_CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_ctrl,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] result,
  output logic        busy,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [3:0]        op_q, op_d;
  logic [31:0]       next_hi, next_lo;

  mdu_arith u_arith (
    .a_i       (a_q),
    .b_i       (b_q),
    .op_i      (op_q),
    .hi_i      (hi_q),
    .lo_i      (lo_q),
    .next_hi_o (next_hi),
    .next_lo_o (next_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MDU_NOP;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (start && is_multicycle(mdu_ctrl)) begin
          a_d     = src_a;
          b_d     = src_b;
          op_d    = mdu_ctrl;
          cnt_d   = is_div(mdu_ctrl) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d = S_BUSY;
        end else if (mdu_ctrl == MDU_MTHI) begin
          hi_d = src_a;
        end else if (mdu_ctrl == MDU_MTLO) begin
          lo_d = src_a;
        end
      end
      S_BUSY: begin
        // Commit on the last busy cycle so HI/LO are fresh when busy drops.
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = next_hi;
          lo_d    = next_lo;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q == S_BUSY);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign result = (mdu_ctrl == MDU_MFHI) ? hi_q :
                  (mdu_ctrl == MDU_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed ops plus a per-cycle reference model.
module tb_mdu_unit;

  localparam int NMULT = 5;
  localparam int NDIV  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mdu_ctrl = 4'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic [31:0] result, hi_o, lo_o;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mdu_unit #(.MULT_CYCLES(NMULT), .DIV_CYCLES(NDIV), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_ctrl(mdu_ctrl),
    .src_a(src_a), .src_b(src_b), .result(result), .busy(busy),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: HI/LO and pending op, updated from the architectural rules.
  logic [31:0] m_hi, m_lo, p_a, p_b;
  logic [3:0]  p_op;
  int          m_rem;

  function automatic logic model_is_md(input logic [3:0] op);
    if (op >= 4'd1 && op <= 4'd4) return 1'b1;
`ifdef MDU_MADD_EN
    if (op >= 4'd9 && op <= 4'd12) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic model_commit();
    longint sa, sb;
    logic [63:0] acc, pr;
    sa  = longint'($signed(p_a));
    sb  = longint'($signed(p_b));
    acc = {m_hi, m_lo};
    case (p_op)
      4'd1: {m_hi, m_lo} = 64'(sa * sb);
      4'd2: {m_hi, m_lo} = {32'd0, p_a} * {32'd0, p_b};
      4'd3: if (p_b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      4'd4: if (p_b != 0) begin m_lo = p_a / p_b; m_hi = p_a % p_b; end
      4'd9:  begin pr = 64'(sa * sb); {m_hi, m_lo} = acc + pr; end
      4'd10: begin pr = {32'd0, p_a} * {32'd0, p_b}; {m_hi, m_lo} = acc + pr; end
      4'd11: begin pr = 64'(sa * sb); {m_hi, m_lo} = acc - pr; end
      4'd12: begin pr = {32'd0, p_a} * {32'd0, p_b}; {m_hi, m_lo} = acc - pr; end
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = 0; m_lo = 0; m_rem = 0; p_op = 0; p_a = 0; p_b = 0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) model_commit();
    end else if (start && model_is_md(mdu_ctrl)) begin
      p_op = mdu_ctrl; p_a = src_a; p_b = src_b;
      m_rem = (mdu_ctrl == 4'd3 || mdu_ctrl == 4'd4) ? NDIV : NMULT;
    end else if (mdu_ctrl == 4'd5) begin
      m_hi = src_a;
    end else if (mdu_ctrl == 4'd6) begin
      m_lo = src_a;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("model_busy", 32'(busy), 32'(m_rem > 0));
      chk("model_hi", hi_o, m_hi);
      chk("model_lo", lo_o, m_lo);
      chk("model_result", result,
          (mdu_ctrl == 4'd7) ? m_hi : (mdu_ctrl == 4'd8) ? m_lo : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy);
    start = 1'b1; mdu_ctrl = op; src_a = a; src_b = b;
    tick();
    start = 1'b0; mdu_ctrl = 4'd0;
    nbusy = 0;
    while (busy && nbusy < 50) begin
      nbusy++;
      tick();
    end
    if (nbusy >= 50) begin
      errors++;
      $display("FAIL busy_timeout: busy still high after %0d cycles", nbusy);
    end
  endtask

  task automatic read_hl(input string name, input logic [31:0] ehi, input logic [31:0] elo);
    mdu_ctrl = 4'd7; #1;
    chk({name, "_mfhi"}, result, ehi);
    mdu_ctrl = 4'd8; #1;
    chk({name, "_mflo"}, result, elo);
    mdu_ctrl = 4'd0;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    mdu_ctrl = op; src_a = v;
    tick();
    mdu_ctrl = 4'd0;
  endtask

  initial begin
    int nb;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi_o, 32'd0);
    chk("reset_lo", lo_o, 32'd0);
    reset = 1'b1;
    tick();

    run_md(4'd1, 32'hFFFFFFFF, 32'd2, nb);
    chk("mult_busy_len", 32'(nb), 32'd5);
    read_hl("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);

    run_md(4'd2, 32'hFFFFFFFF, 32'd2, nb);
    read_hl("multu", 32'h00000001, 32'hFFFFFFFE);

    run_md(4'd1, 32'hFFFFFFFD, 32'd4, nb);
    read_hl("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFF4);

    run_md(4'd3, 32'hFFFFFFF9, 32'd2, nb);
    chk("div_busy_len", 32'(nb), 32'd10);
    read_hl("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

    run_md(4'd4, 32'd7, 32'd2, nb);
    read_hl("divu", 32'd1, 32'd3);

    mt(4'd5, 32'h12345678);
    mt(4'd6, 32'h9ABCDEF0);
    read_hl("mthilo", 32'h12345678, 32'h9ABCDEF0);

    run_md(4'd3, 32'd55, 32'd0, nb);
    chk("div0_busy_len", 32'(nb), 32'd10);
    read_hl("div0", 32'h12345678, 32'h9ABCDEF0);

    run_md(4'd3, 32'h80000000, 32'hFFFFFFFF, nb);
    read_hl("div_ovf", 32'd0, 32'h80000000);

    // MULT pulse during busy cycle 3 of a DIV must be ignored.
    start = 1'b1; mdu_ctrl = 4'd3; src_a = 32'd100; src_b = 32'd7;
    tick();
    nb = 0;
    while (busy && nb < 50) begin
      nb++;
      if (nb == 3) begin start = 1'b1; mdu_ctrl = 4'd1; src_a = 32'd3; src_b = 32'd3; end
      else begin start = 1'b0; mdu_ctrl = 4'd0; end
      tick();
    end
    start = 1'b0; mdu_ctrl = 4'd0;
    chk("div_ignore_busy_len", 32'(nb), 32'd10);
    read_hl("div_ignore", 32'd2, 32'd14);

    // Asynchronous reset mid-MULT.
    start = 1'b1; mdu_ctrl = 4'd1; src_a = 32'd5; src_b = 32'd6;
    tick();
    start = 1'b0; mdu_ctrl = 4'd0;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_hi", hi_o, 32'd0);
    chk("rst_mid_lo", lo_o, 32'd0);
    tick();
    reset = 1'b1;
    repeat (8) tick();
    read_hl("after_rst", 32'd0, 32'd0);

    mt(4'd5, 32'd0);
    mt(4'd6, 32'hFFFFFFFF);
    run_md(4'd10, 32'd1, 32'd1, nb);
`ifdef MDU_MADD_EN
    chk("maddu_busy_len", 32'(nb), 32'd5);
    read_hl("maddu", 32'd1, 32'd0);
    run_md(4'd11, 32'd2, 32'd3, nb);
    read_hl("msub", 32'd0, 32'hFFFFFFFA);
`else
    chk("maddu_nop_busy", 32'(nb), 32'd0);
    read_hl("maddu_nop", 32'd0, 32'hFFFFFFFF);
`endif

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
